// File: rtl/cory_rdma1d_pkg.sv
// Shared definitions for the cory_rdma1d read DMA.
// Contents:
//   - state_t      : controller states (IDLE, RUN, ZERO)
//   - f_log2       : ceiling log2 of a positive constant
//   - f_bus_width  : bytes per data beat for a given data width
//   - f_max_byte   : bytes moved by the longest burst
package cory_rdma1d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    function automatic int f_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int f_bus_width(input int d);
        return d / 8;
    endfunction

    function automatic int f_max_byte(input int l, input int d);
        return (1 << l) * (d / 8);
    endfunction

endpackage

// File: rtl/cory_queue.sv
// Small synchronous FIFO holding the expected length of each outstanding burst.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_a_v, i_a_d    : push strobe and data (caller only pushes when !o_full)
//   o_full          : no free slot
//   o_z_v, o_z_d    : head valid and head data
//   i_z_r           : pop the head when o_z_v
// A push and a pop in the same cycle are both honoured, also when full.
module cory_queue #(
    parameter int N = 4,
    parameter int Q = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_full,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    input  logic         i_z_r
);
    localparam int PW = (Q > 1) ? $clog2(Q) : 1;
    localparam int CW = $clog2(Q + 1);

    logic [N-1:0]  mem [Q];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(Q - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push   = i_a_v;
    assign pop    = i_z_r & o_z_v;
    assign o_full = (cnt == CW'(Q));
    assign o_z_v  = (cnt != '0);
    assign o_z_d  = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= f_next(wp);
            if (pop)  rp <= f_next(rp);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= i_a_d;
    end

endmodule

// File: rtl/cory_rdma1d.sv
// Read-only 1-D DMA. Splits a (base, width) command into read bursts on AR,
// forwards the returning R beats on the dout stream and flags the final beat.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   i_cmd_v/i_cmd_width/i_cmd_base : command in; o_cmd_r pulses on completion
//   o_ar_v/o_ar_a/o_ar_l/i_ar_r    : burst address channel (len = words-1)
//   i_r_v/i_r_l/i_r_d/o_r_r        : read data channel
//   o_dout_v/o_dout_d/o_dout_l/i_dout_r : output stream, o_dout_l on final beat
//   o_err                          : sticky burst-end disagreement flag
module cory_rdma1d
    import cory_rdma1d_pkg::*;
#(
    parameter int A = 32,
    parameter int L = 4,
    parameter int D = 64,
    parameter int R = 11,
    parameter int Q = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_cmd_v,
    input  logic [R-1:0] i_cmd_width,
    input  logic [A-1:0] i_cmd_base,
    output logic         o_cmd_r,
    output logic         o_ar_v,
    output logic [A-1:0] o_ar_a,
    output logic [L-1:0] o_ar_l,
    input  logic         i_ar_r,
    input  logic         i_r_v,
    input  logic         i_r_l,
    input  logic [D-1:0] i_r_d,
    output logic         o_r_r,
    output logic         o_dout_v,
    output logic [D-1:0] o_dout_d,
    output logic         o_dout_l,
    input  logic         i_dout_r,
    output logic         o_err
);
    localparam int BUS_WIDTH = f_bus_width(D);
    localparam int BAW       = f_log2(BUS_WIDTH);
    localparam int MAX_BYTE  = f_max_byte(L, D);
    // Wide enough for both the byte remainder and one full burst.
    localparam int CW = (R + 1 > L + BAW + 1) ? R + 1 : L + BAW + 1;

    state_t         state;
    logic [A-1:0]   ar_addr;
    logic [R-1:0]   ar_rem;
    logic [R-1:0]   beat_rem;
    logic [L-1:0]   rcnt;
    logic           err;

    logic [CW-1:0]  rem_w;
    logic [CW-1:0]  burst_bytes;
    logic [CW-1:0]  burst_words;
    logic [CW-1:0]  cmd_beats;
    logic           run;
    logic           q_full;
    logic           q_v;
    logic [L-1:0]   q_head;
    logic           push;
    logic           rvr;
    logic           burst_last;
    logic           pop;
    logic           cmd_done;

    always_comb begin
        rem_w       = CW'(ar_rem);
        burst_bytes = (rem_w > CW'(MAX_BYTE)) ? CW'(MAX_BYTE) : rem_w;
        burst_words = (burst_bytes + CW'(BUS_WIDTH - 1)) >> BAW;
        cmd_beats   = (CW'(i_cmd_width) + CW'(BUS_WIDTH - 1)) >> BAW;
    end

    assign run        = (state == RUN);
    assign o_ar_v     = run & (ar_rem != '0) & ~q_full;
    assign o_ar_a     = ar_addr;
    assign o_ar_l     = L'(burst_words - CW'(1));
    assign push       = o_ar_v & i_ar_r;

    // R data is only accepted while a burst is expected, so the queue head
    // always describes the beat on the bus.
    assign o_r_r      = run & i_dout_r & q_v;
    assign o_dout_v   = run & i_r_v & q_v;
    assign o_dout_d   = i_r_d;
    assign o_dout_l   = o_dout_v & (beat_rem == R'(1));
    assign rvr        = i_r_v & o_r_r;
    assign burst_last = (rcnt == q_head);
    assign pop        = rvr & burst_last;
    assign cmd_done   = o_dout_v & o_dout_l & i_dout_r;
    assign o_cmd_r    = (state == ZERO) | cmd_done;
    assign o_err      = err;

    cory_queue #(
        .N (L),
        .Q (Q)
    ) u_len_q (
        .clk    (clk),
        .reset  (reset),
        .i_a_v  (push),
        .i_a_d  (o_ar_l),
        .o_full (q_full),
        .o_z_v  (q_v),
        .o_z_d  (q_head),
        .i_z_r  (pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ar_rem   <= '0;
            beat_rem <= '0;
            rcnt     <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_v) begin
                        if (i_cmd_width != '0) begin
                            state    <= RUN;
                            ar_addr  <= i_cmd_base;
                            ar_rem   <= i_cmd_width;
                            beat_rem <= R'(cmd_beats);
                            rcnt     <= '0;
                            err      <= 1'b0;
                        end else begin
                            state <= ZERO;
                        end
                    end
                end
                ZERO: state <= IDLE;
                RUN: begin
                    if (push) begin
                        ar_addr <= ar_addr + A'(burst_bytes);
                        ar_rem  <= ar_rem - R'(burst_bytes);
                    end
                    if (rvr) begin
                        beat_rem <= beat_rem - R'(1);
                        rcnt     <= burst_last ? '0 : rcnt + L'(1);
                        // Our own count keeps governing the pop; the flag only reports.
                        if (i_r_l != burst_last) err <= 1'b1;
                    end
                    if (cmd_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cory_rdma1d.sv
module tb_cory_rdma1d;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cmd_v;
    logic [10:0] i_cmd_width;
    logic [31:0] i_cmd_base;
    logic        o_cmd_r;
    logic        o_ar_v;
    logic [31:0] o_ar_a;
    logic [3:0]  o_ar_l;
    logic        i_ar_r;
    logic        i_r_v;
    logic        i_r_l;
    logic [63:0] i_r_d;
    logic        o_r_r;
    logic        o_dout_v;
    logic [63:0] o_dout_d;
    logic        o_dout_l;
    logic        i_dout_r;
    logic        o_err;

    always #5 clk = ~clk;

    cory_rdma1d dut (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_v     (i_cmd_v),
        .i_cmd_width (i_cmd_width),
        .i_cmd_base  (i_cmd_base),
        .o_cmd_r     (o_cmd_r),
        .o_ar_v      (o_ar_v),
        .o_ar_a      (o_ar_a),
        .o_ar_l      (o_ar_l),
        .i_ar_r      (i_ar_r),
        .i_r_v       (i_r_v),
        .i_r_l       (i_r_l),
        .i_r_d       (i_r_d),
        .o_r_r       (o_r_r),
        .o_dout_v    (o_dout_v),
        .o_dout_d    (o_dout_d),
        .o_dout_l    (o_dout_l),
        .i_dout_r    (i_dout_r),
        .o_err       (o_err)
    );

    typedef struct { logic [31:0] a; int len; int rdy; } burst_t;
    typedef struct { logic [31:0] a; int len; } ar_t;

    burst_t      mem_q[$];
    ar_t         exp_ar[$];
    logic [63:0] exp_d[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int mem_beat = 0;
    int mem_bno = 0;
    int r_delay = 0;
    int dr_mode = 0;
    int arr_mode = 0;
    int gaps = 0;
    int inj_beat = -1;
    int ar_cnt = 0;
    int n_exp_ar = 0;
    int ar_at_first_r = -1;
    int first_last_cyc = -1;
    int ar3_cyc = -1;
    int chk_rr = 0;
    logic r_pending = 1'b0;
    logic [31:0] salt = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
        return {a + 32'(i * 8), salt ^ 32'(i)};
    endfunction

    // Reference: split width bytes into <=128-byte bursts and list every beat.
    task automatic build_exp(input logic [31:0] base, input int width);
        int rem;
        int b;
        int words;
        logic [31:0] a;
        exp_ar.delete();
        exp_d.delete();
        rem = width;
        a = base;
        while (rem > 0) begin
            b = (rem > 128) ? 128 : rem;
            words = (b + 7) / 8;
            exp_ar.push_back('{a, words - 1});
            for (int i = 0; i < words; i++) exp_d.push_back(beat_data(a, i));
            a = a + 32'(b);
            rem = rem - b;
        end
        n_exp_ar = exp_ar.size();
    endtask

    // One clock: drive at the falling edge, sample just after, account the
    // handshakes that the next rising edge will take.
    task automatic step();
        logic ar_hs;
        logic r_hs;
        logic d_hs;
        @(negedge clk);
        case (dr_mode)
            0:       i_dout_r = 1'b1;
            1:       i_dout_r = ~i_dout_r;
            default: i_dout_r = 1'($urandom_range(0, 1));
        endcase
        i_ar_r = (arr_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!r_pending) begin
            i_r_v = (mem_q.size() > 0) && (cyc >= mem_q[0].rdy) &&
                    (gaps == 0 || $urandom_range(0, 3) != 0);
        end
        if (i_r_v) begin
            i_r_d = beat_data(mem_q[0].a, mem_beat);
            i_r_l = (mem_beat == mem_q[0].len) ||
                    (inj_beat >= 0 && mem_bno == 0 && mem_beat == inj_beat);
        end else begin
            i_r_d = {$urandom, $urandom};
            i_r_l = 1'b0;
        end
        #1;
        ar_hs = o_ar_v & i_ar_r;
        r_hs  = i_r_v & o_r_r;
        d_hs  = o_dout_v & i_dout_r;
        if (chk_rr != 0) chk("r_r_mirror", o_r_r, i_dout_r && (mem_q.size() > 0));
        if (d_hs) begin
            if (exp_d.size() == 0) begin
                chk("dout_extra", 1, 0);
            end else begin
                chk("dout_d", o_dout_d, exp_d[0]);
                chk("dout_l", o_dout_l, exp_d.size() == 1);
                chk("cmd_r_last", o_cmd_r, exp_d.size() == 1);
                void'(exp_d.pop_front());
            end
        end
        if (r_hs) begin
            if (ar_at_first_r < 0) ar_at_first_r = ar_cnt;
            if (mem_beat == mem_q[0].len) begin
                void'(mem_q.pop_front());
                mem_beat = 0;
                mem_bno++;
                if (first_last_cyc < 0) first_last_cyc = cyc;
            end else begin
                mem_beat++;
            end
        end
        if (ar_hs) begin
            if (exp_ar.size() == 0) begin
                chk("ar_extra", 1, 0);
            end else begin
                chk("ar_a", o_ar_a, exp_ar[0].a);
                chk("ar_l", o_ar_l, exp_ar[0].len);
                void'(exp_ar.pop_front());
            end
            mem_q.push_back('{o_ar_a, int'(o_ar_l), cyc + 1 + r_delay});
            ar_cnt++;
            if (ar_cnt == 3) ar3_cyc = cyc;
        end
        r_pending = i_r_v & ~r_hs;
        cyc++;
    endtask

    task automatic start_cmd(input logic [31:0] base, input int width);
        salt = $urandom;
        build_exp(base, width);
        mem_bno = 0;
        ar_cnt = 0;
        ar_at_first_r = -1;
        first_last_cyc = -1;
        ar3_cyc = -1;
        i_cmd_base = base;
        i_cmd_width = 11'(width);
        i_cmd_v = 1'b1;
    endtask

    task automatic wait_done(input logic exp_err);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            step();
            if (o_cmd_r) done = 1'b1;
        end
        i_cmd_v = 1'b0;
        chk("done_timeout", done, 1);
        chk("ar_left", exp_ar.size(), 0);
        chk("dout_left", exp_d.size(), 0);
        chk("ar_count", ar_cnt, n_exp_ar);
        chk("err", o_err, exp_err);
        step();
        chk("cmd_r_pulse", o_cmd_r, 0);
        chk("idle_ar_v", o_ar_v, 0);
    endtask

    task automatic run_cmd(input logic [31:0] base, input int width, input logic exp_err);
        start_cmd(base, width);
        wait_done(exp_err);
    endtask

    initial begin
        reset = 1'b1;
        i_cmd_v = 1'b0;
        i_cmd_width = '0;
        i_cmd_base = '0;
        i_ar_r = 1'b0;
        i_r_v = 1'b0;
        i_r_l = 1'b0;
        i_r_d = '0;
        i_dout_r = 1'b0;
        repeat (3) step();
        chk("rst_ar_v", o_ar_v, 0);
        chk("rst_r_r", o_r_r, 0);
        chk("rst_dout_v", o_dout_v, 0);
        chk("rst_cmd_r", o_cmd_r, 0);
        chk("rst_err", o_err, 0);
        reset = 1'b0;
        step();

        // Multi-burst with all readies high.
        run_cmd(32'h1000, 300, 1'b0);

        // Outstanding limit with slow memory.
        r_delay = 20;
        run_cmd(32'h2000, 1024, 1'b0);
        chk("ar_before_r", ar_at_first_r, 2);
        chk("ar3_timing", ar3_cyc, first_last_cyc + 1);
        r_delay = 0;

        // Output backpressure.
        dr_mode = 1;
        chk_rr = 1;
        run_cmd(32'h3000, 64, 1'b0);
        chk_rr = 0;
        dr_mode = 0;

        // Edge sizes.
        run_cmd(32'h4000, 0, 1'b0);
        run_cmd(32'h4123, 1, 1'b0);
        run_cmd(32'h5000, 128, 1'b0);

        // Early last-of-burst from memory.
        inj_beat = 3;
        run_cmd(32'h6000, 128, 1'b1);
        step();
        chk("err_sticky", o_err, 1);
        inj_beat = -1;
        run_cmd(32'h6100, 40, 1'b0);

        // Reset during the second burst.
        start_cmd(32'h7000, 1024);
        for (int n = 0; n < 500 && !(mem_bno == 1 && mem_beat >= 2); n++) step();
        chk("reached_burst2", mem_bno == 1 && mem_beat >= 2, 1);
        reset = 1'b1;
        i_cmd_v = 1'b0;
        step();
        chk("mid_rst_ar_v", o_ar_v, 0);
        chk("mid_rst_r_r", o_r_r, 0);
        chk("mid_rst_dout_v", o_dout_v, 0);
        chk("mid_rst_cmd_r", o_cmd_r, 0);
        chk("mid_rst_err", o_err, 0);
        mem_q.delete();
        mem_beat = 0;
        r_pending = 1'b0;
        reset = 1'b0;
        step();
        dr_mode = 2;
        arr_mode = 1;
        gaps = 1;
        run_cmd(32'h7777, 500, 1'b0);

        // Random commands under random stalls.
        for (int k = 0; k < 4; k++) begin
            r_delay = $urandom_range(0, 6);
            run_cmd($urandom, $urandom_range(1, 2047), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
